// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 default timing constants, per-axis total/sync-window derivation, counter-width sizing check
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int DEF_CNT_W = 10;
  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction
  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction
  function automatic bit cnt_fits(input int w, input int h_total, input int v_total);
    return (longint'(1) << w) >= longint'((h_total > v_total) ? h_total : v_total);
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis; Clk, reset, inc_en (advance), upd_en (refresh registered decodes) -> count, wrap (count at last), active, sync decoded from next count
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP = DEF_H_FP,
  parameter int SYNC = DEF_H_SYNC,
  parameter int BP = DEF_H_BP,
  parameter bit POL = 1'b0,
  parameter int W = DEF_CNT_W
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic         inc_en,
  input  logic         upd_en,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active,
  output logic         sync
);
  localparam logic [W-1:0] LAST = W'(axis_total(ACTIVE, FP, SYNC, BP) - 1);
  localparam logic [W-1:0] ACT = W'(ACTIVE);
  localparam logic [W-1:0] SS = W'(sync_start(ACTIVE, FP));
  localparam logic [W-1:0] SE = W'(sync_end(ACTIVE, FP, SYNC));
  logic [W-1:0] nxt;
  assign wrap = count == LAST;
  assign nxt = !inc_en ? count : wrap ? '0 : count + 1'b1;
  always_ff @(posedge Clk) begin
    if (reset) begin
      count <= '0;
      active <= 1'b0;
      sync <= ~POL;
    end else if (upd_en) begin
      count <= nxt;
      active <= nxt < ACT;
      sync <= (nxt >= SS && nxt < SE) ? POL : ~POL;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA timing; Clk, reset, pix_en in -> hcount, vcount, hsync, vsync, video_on, line_start, frame_start, all aligned one Clk after the pix_en edge
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start
);
  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  if (!cnt_fits(CNT_W, H_TOTAL, V_TOTAL)) begin : g_cnt_w_check
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end
  logic h_wrap, v_wrap, h_active, v_active;
  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .W(CNT_W)
  ) u_h (
    .Clk(Clk), .reset(reset), .inc_en(pix_en), .upd_en(pix_en),
    .count(hcount), .wrap(h_wrap), .active(h_active), .sync(hsync)
  );
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .W(CNT_W)
  ) u_v (
    .Clk(Clk), .reset(reset), .inc_en(pix_en & h_wrap), .upd_en(pix_en),
    .count(vcount), .wrap(v_wrap), .active(v_active), .sync(vsync)
  );
  assign video_on = h_active & v_active;
  always_ff @(posedge Clk) begin
    line_start <= ~reset & pix_en & h_wrap;
    frame_start <= ~reset & pix_en & h_wrap & v_wrap;
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized pix_en against a tick-count position model for default, 800x600 and tiny timings
module tb_vga_timing_gen;
  typedef struct packed {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } cfg_t;
  logic Clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;
  logic [9:0] hc0, vc0;
  logic [10:0] hc1, vc1;
  logic [3:0] hc2, vc2;
  logic hs0, vs0, vo0, ls0, fs0;
  logic hs1, vs1, vo1, ls1, fs1;
  logic hs2, vs2, vo2, ls2, fs2;
  int passes = 0;
  int checks = 0;
  longint n [3];
  bit last_rst, last_en, armed;
  cfg_t c0, c1, c2;
  always #5 Clk = ~Clk;
  vga_timing_gen u_def (
    .Clk(Clk), .reset(reset), .pix_en(pix_en), .hcount(hc0), .vcount(vc0),
    .hsync(hs0), .vsync(vs0), .video_on(vo0), .line_start(ls0), .frame_start(fs0)
  );
  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(11)
  ) u_svga (
    .Clk(Clk), .reset(reset), .pix_en(pix_en), .hcount(hc1), .vcount(vc1),
    .hsync(hs1), .vsync(vs1), .video_on(vo1), .line_start(ls1), .frame_start(fs1)
  );
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CNT_W(4)
  ) u_tiny (
    .Clk(Clk), .reset(reset), .pix_en(pix_en), .hcount(hc2), .vcount(vc2),
    .hsync(hs2), .vsync(vs2), .video_on(vo2), .line_start(ls2), .frame_start(fs2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
  endtask
  task automatic check_inst(input string nm, input cfg_t c, input longint cnt,
                            input logic [31:0] hc, input logic [31:0] vc,
                            input logic hs, input logic vs, input logic vo,
                            input logic ls, input logic fs);
    int ht, vt, h, v;
    longint p;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    p = cnt % longint'(ht * vt);
    h = int'(p % longint'(ht));
    v = int'(p / longint'(ht));
    check({nm, ".hcount"}, hc, 32'(h));
    check({nm, ".vcount"}, vc, 32'(v));
    check({nm, ".hsync"}, 32'(hs), 32'((h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hp : !c.hp));
    check({nm, ".vsync"}, 32'(vs), 32'((v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vp : !c.vp));
    check({nm, ".video_on"}, 32'(vo), 32'(cnt > 0 && h < c.ha && v < c.va));
    check({nm, ".line_start"}, 32'(ls), 32'(!last_rst && last_en && h == 0));
    check({nm, ".frame_start"}, 32'(fs), 32'(!last_rst && last_en && h == 0 && v == 0));
  endtask
  task automatic step(input bit r, input bit e);
    @(negedge Clk);
    if (armed) begin
      check_inst("def", c0, n[0], 32'(hc0), 32'(vc0), hs0, vs0, vo0, ls0, fs0);
      check_inst("svga", c1, n[1], 32'(hc1), 32'(vc1), hs1, vs1, vo1, ls1, fs1);
      check_inst("tiny", c2, n[2], 32'(hc2), 32'(vc2), hs2, vs2, vo2, ls2, fs2);
    end
    reset = r;
    pix_en = e;
    last_rst = r;
    last_en = e;
    for (int i = 0; i < 3; i++) n[i] = r ? 0 : n[i] + longint'(e);
    armed = 1'b1;
  endtask
  initial begin
    c0 = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, hp: 1'b0, vp: 1'b0};
    c1 = '{ha: 800, hf: 40, hs: 128, hb: 88, va: 600, vf: 1, vs: 4, vb: 23, hp: 1'b1, vp: 1'b1};
    c2 = '{ha: 8, hf: 2, hs: 3, hb: 2, va: 4, vf: 1, vs: 2, vb: 1, hp: 1'b1, vp: 1'b0};
    armed = 1'b0;
    for (int i = 0; i < 3; i++) n[i] = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 5000; i++) step(1'b0, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 3000 && n[0] % 800 != 700; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("seek.hcount700", 32'(hc0), 32'd700);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    for (int i = 0; i < 1700; i++) step(1'b0, i % 2 == 0);
    for (int i = 0; i < 3000; i++) step(1'b0, $urandom_range(0, 3) != 0);
    step(1'b0, 1'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
